// File: rtl/keypad_interrupt_gen.sv
// rtl/keypad_interrupt_gen.sv - keypad matrix scanner, switch debouncer and interrupt bus encoder
module keypad_interrupt_gen #(
  parameter int SCAN_DIV   = 100,
  parameter int DEB_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sw_reset,
  input  logic [1:0]  sw_red,
  input  logic [1:0]  sw_green,
  input  logic [1:0]  sw_blue,
  input  logic        sw_pause,
  input  logic [3:0]  key_row,
  output logic [2:0]  key_col,
  output logic [19:0] interrupt,
  output logic        key_event
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEB_FRAMES > 1) ? $clog2(DEB_FRAMES) : 1;

  logic [7:0]    sw_meta, sw_sync;
  logic [3:0]    row_meta, row_sync;
  logic [CW-1:0] cnt;
  logic [1:0]    col;
  logic [11:0]   raw, raw_next;
  logic [19:0]   sample, stable, suppressed;
  logic [DW-1:0] deb_cnt [20];
  logic          deb_go;
  logic          last_cnt, frame_end, multi_key;

  assign last_cnt  = (cnt == CW'(SCAN_DIV - 1));
  assign frame_end = last_cnt && (col == 2'd2);
  assign key_col   = 3'(3'b001 << col);

  // Bit b of the key field holds key index k = 11-b, located at row k/3, column k%3.
  for (genvar b = 0; b < 12; b++) begin : g_raw
    localparam int K = 11 - b;
    assign raw_next[b] = (last_cnt && (col == 2'(K % 3))) ? row_sync[K / 3] : raw[b];
  end

  assign multi_key  = |(stable[11:0] & (stable[11:0] - 12'd1));
  assign suppressed = {stable[19:12], multi_key ? 12'h000 : stable[11:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      row_meta <= '0;
      row_sync <= '0;
      cnt      <= '0;
      col      <= '0;
      raw      <= '0;
      sample   <= '0;
      deb_go   <= 1'b0;
    end else begin
      sw_meta  <= {sw_reset, sw_red, sw_green, sw_blue, sw_pause};
      sw_sync  <= sw_meta;
      row_meta <= key_row;
      row_sync <= row_meta;
      raw      <= raw_next;
      deb_go   <= frame_end;
      if (frame_end)
        sample <= {sw_sync, raw_next};
      if (last_cnt) begin
        cnt <= '0;
        col <= (col == 2'd2) ? 2'd0 : col + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Per-bit debounce: a bit flips only after DEB_FRAMES consecutive disagreeing frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < 20; i++)
        deb_cnt[i] <= '0;
    end else if (deb_go) begin
      for (int i = 0; i < 20; i++) begin
        if (sample[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_FRAMES - 1)) begin
          stable[i]  <= sample[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      interrupt <= '0;
      key_event <= 1'b0;
    end else begin
      interrupt <= suppressed;
      key_event <= (suppressed != interrupt);
    end
  end

endmodule
